// File: rtl/fetch_controller_pkg.sv
// Shared encodings for the instruction-fetch controller.
package fetch_controller_pkg;

  localparam int FETCH_ST_WIDTH = 2;

  typedef enum logic [FETCH_ST_WIDTH-1:0] {
    FETCH_ST_IDLE  = 2'd0,
    FETCH_ST_FETCH = 2'd1,
    FETCH_ST_DRAIN = 2'd2,
    FETCH_ST_VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_controller_adder.sv
// Plain modulo-2^W adder used for the PC increment.
module fetch_controller_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, talks to a multi-cycle imem
// over req/ready and presents one instruction at a time to IF/ID.
//
// state | meaning
// IDLE  | one idle cycle after reset, no request
// FETCH | request outstanding for fetch_pc, data will be kept
// DRAIN | request outstanding for a squashed address, data will be dropped
// VALID | instruction presented to IF/ID, waiting to be consumed
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] PC_INC     = 1,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = 0,
  parameter int                    MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Freeze,
  input  logic                  Branch_Taken,
  input  logic [WORD_WIDTH-1:0] Branch_Address,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic [WORD_WIDTH-1:0] PC_Stage_out,
  output logic                  imem_timeout
);

  localparam int                WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  fetch_state_e          state, state_nxt;
  logic [WORD_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [WORD_WIDTH-1:0] pend_target, pend_target_nxt;
  logic [WORD_WIDTH-1:0] instruction_nxt, pc_stage_nxt, pc_plus;
  logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
  logic                  timeout_nxt;
  logic                  transfer;

  fetch_controller_adder #(.W(WORD_WIDTH)) u_pc_adder (
    .a   (fetch_pc),
    .b   (PC_INC),
    .sum (pc_plus)
  );

  assign imem_req    = (state == FETCH_ST_FETCH) || (state == FETCH_ST_DRAIN);
  assign imem_addr   = fetch_pc;
  assign instr_valid = (state == FETCH_ST_VALID);
  assign transfer    = imem_req && imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH_ST_IDLE;
      fetch_pc     <= RESET_PC;
      pend_target  <= '0;
      instruction  <= '0;
      PC_Stage_out <= '0;
      wait_cnt     <= '0;
      imem_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      pend_target  <= pend_target_nxt;
      instruction  <= instruction_nxt;
      PC_Stage_out <= pc_stage_nxt;
      wait_cnt     <= wait_cnt_nxt;
      imem_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    pend_target_nxt = pend_target;
    instruction_nxt = instruction;
    pc_stage_nxt    = PC_Stage_out;

    unique case (state)
      FETCH_ST_IDLE: begin
        if (Branch_Taken) fetch_pc_nxt = Branch_Address;
        state_nxt = FETCH_ST_FETCH;
      end
      FETCH_ST_FETCH: begin
        if (Branch_Taken && imem_ready) begin
          fetch_pc_nxt = Branch_Address;
        end else if (Branch_Taken) begin
          pend_target_nxt = Branch_Address;
          state_nxt       = FETCH_ST_DRAIN;
        end else if (imem_ready) begin
          instruction_nxt = imem_rdata;
          pc_stage_nxt    = pc_plus;
          fetch_pc_nxt    = pc_plus;
          state_nxt       = FETCH_ST_VALID;
        end
      end
      FETCH_ST_DRAIN: begin
        // Latest redirect wins, including one arriving with the drained data.
        if (Branch_Taken) pend_target_nxt = Branch_Address;
        if (imem_ready) begin
          fetch_pc_nxt = Branch_Taken ? Branch_Address : pend_target;
          state_nxt    = FETCH_ST_FETCH;
        end
      end
      FETCH_ST_VALID: begin
        if (Branch_Taken) begin
          fetch_pc_nxt = Branch_Address;
          state_nxt    = FETCH_ST_FETCH;
        end else if (!Freeze) begin
          state_nxt = FETCH_ST_FETCH;
        end
      end
      default: state_nxt = FETCH_ST_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = imem_timeout;
    if (transfer) begin
      wait_cnt_nxt = '0;
    end else if (imem_req) begin
      if (wait_cnt < WAIT_MAX) wait_cnt_nxt = wait_cnt + 1'b1;
      if (wait_cnt_nxt == WAIT_MAX) timeout_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random
// traffic compared every cycle against a transaction-level fetch model.
module tb_fetch_controller;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Freeze = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Address = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] PC_Stage_out;
  logic        imem_timeout;

  fetch_controller #(
    .WORD_WIDTH (32),
    .PC_INC     (32'd1),
    .RESET_PC   (32'd0),
    .MAX_WAIT   (MW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Freeze         (Freeze),
    .Branch_Taken   (Branch_Taken),
    .Branch_Address (Branch_Address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .PC_Stage_out   (PC_Stage_out),
    .imem_timeout   (imem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request is either outstanding (possibly squashed, with a pending
  // redirect target) or an instruction is sitting in IF/ID waiting to go.
  bit          m_started, m_req, m_squash, m_valid, m_tmo;
  logic [31:0] m_pc, m_target, m_instr, m_pcs;
  int          m_waits;

  task automatic model_reset();
    m_started = 0; m_req = 0; m_squash = 0; m_valid = 0; m_tmo = 0;
    m_pc = 0; m_target = 0; m_instr = 0; m_pcs = 0; m_waits = 0;
  endtask

  task automatic model_step(input bit br, input logic [31:0] ba, input bit frz, input bit rdy);
    if (!m_started) begin
      m_started = 1;
      if (br) m_pc = ba;
      m_req = 1;
    end else if (m_req) begin
      if (rdy) m_waits = 0;
      else begin
        m_waits = (m_waits + 1 > MW) ? MW : m_waits + 1;
        if (m_waits == MW) m_tmo = 1;
      end
      if (m_squash) begin
        if (br) m_target = ba;
        if (rdy) begin
          m_pc = m_target;
          m_squash = 0;
        end
      end else if (br && rdy) begin
        m_pc = ba;
      end else if (br) begin
        m_squash = 1;
        m_target = ba;
      end else if (rdy) begin
        m_instr = mem_word(m_pc);
        m_pc = m_pc + 32'd1;
        m_pcs = m_pc;
        m_valid = 1;
        m_req = 0;
      end
    end else if (m_valid) begin
      if (br) begin
        m_pc = ba;
        m_valid = 0;
        m_req = 1;
      end else if (!frz) begin
        m_valid = 0;
        m_req = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(Branch_Taken, Branch_Address, Freeze, imem_ready);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        check("m_req", {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) check("m_addr", imem_addr, m_pc);
        check("m_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        check("m_instr", instruction, m_instr);
        check("m_pcs", PC_Stage_out, m_pcs);
        check("m_timeout", {31'd0, imem_timeout}, {31'd0, m_tmo});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid_pcs(input logic [31:0] pcs, input int bound);
    int n = 0;
    while (!(instr_valid && PC_Stage_out == pcs) && n < bound) begin
      tick();
      n++;
    end
    check("wait_valid_pcs", {31'd0, instr_valid && PC_Stage_out == pcs}, 32'd1);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_timeout", {31'd0, imem_timeout}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_pcs", PC_Stage_out, 32'd0);
    chk_en = 1'b1;

    // Sequential zero-wait fetch
    imem_ready = 1'b1;
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("seq_req", {31'd0, imem_req}, 32'd1);
      check("seq_addr", imem_addr, k);
      check("seq_novalid", {31'd0, instr_valid}, 32'd0);
      tick();
      check("seq_valid", {31'd0, instr_valid}, 32'd1);
      check("seq_pcs", PC_Stage_out, k + 1);
      check("seq_instr", instruction, mem_word(k));
      tick();
    end

    // Freeze while address 5 is presented
    wait_valid_pcs(32'd6, 20);
    Freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_valid", {31'd0, instr_valid}, 32'd1);
      check("frz_pcs", PC_Stage_out, 32'd6);
      check("frz_instr", instruction, mem_word(32'd5));
      check("frz_req", {31'd0, imem_req}, 32'd0);
    end
    Freeze = 1'b0;
    tick();
    check("frz_next_addr", imem_addr, 32'd6);

    // Branch in the 2nd wait cycle of a 3-wait fetch
    imem_ready = 1'b0;
    tick();
    Branch_Taken = 1'b1;
    Branch_Address = 32'h40;
    tick();
    Branch_Taken = 1'b0;
    check("drn_addr", imem_addr, 32'd6);
    check("drn_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("drn_addr2", imem_addr, 32'd6);
    imem_ready = 1'b1;
    tick();
    check("drn_novalid", {31'd0, instr_valid}, 32'd0);
    check("drn_new_addr", imem_addr, 32'h40);
    tick();
    check("drn_pcs", PC_Stage_out, 32'h41);
    check("drn_instr", instruction, mem_word(32'h40));

    // Two branches while draining; the later one wins
    imem_ready = 1'b0;
    tick();
    Branch_Taken = 1'b1;
    Branch_Address = 32'h40;
    tick();
    Branch_Address = 32'h80;
    tick();
    Branch_Taken = 1'b0;
    check("two_old_addr", imem_addr, 32'h41);
    imem_ready = 1'b1;
    tick();
    check("two_new_addr", imem_addr, 32'h80);
    tick();
    check("two_pcs", PC_Stage_out, 32'h81);

    // Branch beats Freeze in VALID
    Branch_Taken = 1'b1;
    Branch_Address = 32'h10;
    Freeze = 1'b1;
    tick();
    Branch_Taken = 1'b0;
    Freeze = 1'b0;
    check("bf_valid", {31'd0, instr_valid}, 32'd0);
    check("bf_addr", imem_addr, 32'h10);

    // Timeout, then reset mid-wait
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_ready = 1'b0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("tmo_flag", {31'd0, imem_timeout}, (i >= MW) ? 32'd1 : 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    check("tmo_sticky", {31'd0, imem_timeout}, 32'd1);
    check("tmo_valid", {31'd0, instr_valid}, 32'd1);
    imem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_async_req", {31'd0, imem_req}, 32'd0);
    check("rst_async_tmo", {31'd0, imem_timeout}, 32'd0);
    imem_ready = 1'b1;
    tick();
    check("rst_hold_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_late_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_late_addr", imem_addr, 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      Branch_Taken = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       Branch_Address = 32'hFFFF_FFFF;
        1:       Branch_Address = 32'hFFFF_FFFE;
        default: Branch_Address = $urandom;
      endcase
      Freeze     = ($urandom_range(0, 2) == 0);
      imem_ready = ($urandom_range(0, 9) < 4);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    Branch_Taken = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch from a multi-cycle instruction memory using a req/ready handshake.
- Owns the fetch PC and presents one instruction at a time to the IF/ID pipeline register.
- Honours the pipeline Freeze and redirects fetch on Branch_Taken.
- An in-flight memory access is never aborted. Data returned for a squashed fetch is discarded.

Parameters:
- WORD_WIDTH, 32, width of PC, addresses and instructions.
- PC_INC, 1, PC increment per instruction (word addressing).
- RESET_PC, 0, fetch address after reset.
- MAX_WAIT, 15, maximum cycles imem_req may wait for imem_ready before imem_timeout is raised.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- Freeze  in  1  downstream stall; a presented instruction is not consumed while high.
- Branch_Taken  in  1  redirect request, sampled every cycle.
- Branch_Address  in  WORD_WIDTH  redirect target.
- imem_req  out  1  memory request.
- imem_addr  out  WORD_WIDTH  memory address; stable while imem_req is high.
- imem_ready  in  1  memory has accepted the request and imem_rdata is valid this cycle.
- imem_rdata  in  WORD_WIDTH  memory read data.
- instruction  out  WORD_WIDTH  captured instruction.
- instr_valid  out  1  instruction presented to IF/ID.
- PC_Stage_out  out  WORD_WIDTH  address of the presented instruction plus PC_INC.
- imem_timeout  out  1  sticky error flag.

Behaviour:
- Reset (async, all outputs registered or decoded from state):
  - state=IDLE, fetch_pc=RESET_PC, instruction=0, PC_Stage_out=0, instr_valid=0, imem_req=0, imem_timeout=0, wait_cnt=0, pend_target=0.
- Handshake:
  - A transfer occurs on a cycle with imem_req && imem_ready.
  - imem_req and imem_addr are decoded from the state and fetch_pc; they are held until the transfer.
- States:
  - IDLE: imem_req=0. Always go to FETCH on the next cycle. A Branch_Taken in this cycle loads fetch_pc from Branch_Address.
  - FETCH: imem_req=1, imem_addr=fetch_pc.
    - Branch_Taken && imem_ready: discard the data, fetch_pc<=Branch_Address, stay in FETCH.
    - Branch_Taken && !imem_ready: pend_target<=Branch_Address, go to DRAIN.
    - imem_ready (no branch): instruction<=imem_rdata, PC_Stage_out<=fetch_pc+PC_INC, fetch_pc<=fetch_pc+PC_INC, instr_valid<=1, go to VALID.
    - Otherwise: stay in FETCH.
  - DRAIN: imem_req=1, imem_addr=fetch_pc (the old, squashed address).
    - A Branch_Taken overwrites pend_target; the latest branch wins.
    - On imem_ready: discard the data. Then fetch_pc<=pend_target, go to FETCH. If Branch_Taken is also high in that cycle, Branch_Address is used instead of pend_target.
  - VALID: imem_req=0, instr_valid=1.
    - Branch_Taken: instr_valid<=0, fetch_pc<=Branch_Address, go to FETCH. Branch wins over Freeze.
    - Otherwise, !Freeze: the instruction is consumed this cycle; instr_valid<=0, go to FETCH.
    - Otherwise (Freeze): hold; instruction and PC_Stage_out stay stable.
- Throughput and latency:
  - Zero-wait memory: one instruction per 2 cycles.
  - Latency from req to instr_valid is (wait cycles + 1).
- Arithmetic: fetch_pc+PC_INC is modulo 2^WORD_WIDTH; 0xFFFFFFFF wraps to 0 with no flag.
- Timeout:
  - wait_cnt increments each cycle imem_req && !imem_ready and clears on a transfer.
  - When wait_cnt reaches MAX_WAIT: imem_timeout<=1 (sticky until rst), wait_cnt saturates.
  - The FSM keeps waiting; the flag is diagnostic only.
- Reset mid-fetch: everything returns to IDLE immediately. A late imem_ready after reset is ignored because imem_req=0 in IDLE.

Decomposition:
- constants.h already provides WORD_WIDTH. Add FETCH_ST_IDLE/FETCH/DRAIN/VALID as 2-bit encodings and the FETCH_ST_WIDTH define.
- Reuse the existing Adder sub-module for fetch_pc+PC_INC.
- The FSM, wait counter and output registers all stay in this one module.

Test Plan:
- Sequential fetch, zero-wait memory (ready tied high), RESET_PC=0, Freeze=0 -> instr_valid pulses every 2nd cycle; imem_addr sequence is 0,1,2,3; PC_Stage_out is 1,2,3,4; instruction matches memory contents.
- Freeze during VALID: assert Freeze for 3 cycles while the instruction at address 5 is presented -> instr_valid, instruction and PC_Stage_out stay constant for 3 cycles; imem_req=0; the next request addresses 6.
- Branch during a 3-wait fetch: Branch_Taken with Branch_Address=0x40 in the 2nd wait cycle -> req stays high at the old address until ready; that data never reaches instr_valid; next imem_addr=0x40.
- Two branches in DRAIN: Branch_Address 0x40, then 0x80 -> 0x80 is fetched and 0x40 is never requested.
- Branch and Freeze both high in VALID: Branch_Address=0x10 -> instr_valid=0 next cycle, next imem_addr=0x10.
- Timeout with MAX_WAIT=4 and ready held low for 6 cycles: imem_timeout rises after the 4th wait cycle and stays 1 after the transfer. Asserting rst mid-wait clears it, and imem_req=0 while rst is high.
